// File: rtl/apb_regbank_pkg.sv
// Shared definitions for the APB register bank: FSM state encoding, wait-state limits
// and the byte-strobe merge helper.
package apb_regbank_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_DW   = 64;
    localparam int unsigned MAX_SW   = MAX_DW / 8;

    // Sized for the widest supported bus; callers zero-extend and truncate.
    function automatic logic [MAX_DW-1:0] strobe_merge(
        input logic [MAX_DW-1:0] old_val,
        input logic [MAX_DW-1:0] wdata,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] merged;
        merged = old_val;
        for (int unsigned b = 0; b < MAX_SW; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Access-phase wait-state counter: loads on setup, counts down during access,
// flags done when it reaches zero.
module apb_wait_counter
    import apb_regbank_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/apb_regbank_slave.sv
// APB4 register bank with byte strobes, hardware-fed read-only registers, wait states,
// error responses and write-notify pulses. Define APB_PRIV_CHECK_EN to reject unprivileged access.
module apb_regbank_slave
    import apb_regbank_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR   = 32'h0,
    parameter int unsigned  DATA_WIDTH  = 32,
    parameter int unsigned  N_REGS      = 8,
    parameter int unsigned  WAIT_STATES = 0,
    parameter logic [N_REGS-1:0] RO_MASK = '0
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic [31:0]                  paddr,
    input  logic [2:0]                   pprot,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [DATA_WIDTH-1:0]        pwdata,
    input  logic [DATA_WIDTH/8-1:0]      pstrb,
    output logic                         pready,
    output logic [DATA_WIDTH-1:0]        prdata,
    output logic                         pslverr,
    output logic [N_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [N_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [N_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRIDE  = DATA_WIDTH / 8;
    localparam int unsigned ALIGN_W = $clog2(STRIDE);
    localparam int unsigned IDX_W   = $clog2(N_REGS);
    localparam logic [31:0] SPAN    = 32'(N_REGS * STRIDE);

    state_e                r_state;
    logic [N_REGS-1:0]     r_wr_pulse;
    logic [N_REGS-1:0]     w_pulse_d;
    logic [31:0]           w_offset;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_hit;
    logic                  w_misaligned;
    logic                  w_ro;
    logic                  w_priv_err;
    logic                  w_err;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_done;
    logic                  w_commit_wr;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_unused;

    // Address decode
    assign w_offset     = paddr - BASE_ADDR;
    assign w_hit        = (paddr >= BASE_ADDR) && (w_offset < SPAN);
    assign w_misaligned = (w_offset[ALIGN_W-1:0] != '0);
    assign w_idx        = w_offset[ALIGN_W +: IDX_W];

    // Only a decoded hit may select a register, so out-of-range indices never alias.
    always_comb begin
        w_ro     = 1'b0;
        w_rd_val = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (w_hit && (w_idx == IDX_W'(i))) begin
                w_ro     = RO_MASK[i];
                w_rd_val = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef APB_PRIV_CHECK_EN
    assign w_priv_err = ~pprot[0];
`else
    assign w_priv_err = 1'b0;
`endif

    assign w_err = ~w_hit | w_misaligned | (pwrite & w_ro) | w_priv_err;

    // Transfer handshake
    assign w_setup     = (r_state == IDLE) && psel && !penable;
    assign w_access    = (r_state == ACCESS) && psel && penable;
    assign pready      = w_access && w_done;
    assign pslverr     = pready && w_err;
    assign prdata      = (pready && !pwrite && !w_err) ? w_rd_val : '0;
    assign w_commit_wr = pready && pwrite && !w_err;

    apb_wait_counter u_wait_counter (
        .i_clk      (pclk),
        .i_rst_n    (presetn),
        .i_load     (w_setup),
        .i_load_val (CNT_W'(WAIT_STATES)),
        .i_dec      (w_access),
        .o_done     (w_done)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Dropping psel mid-access aborts without commit.
                    if (!psel || pready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_pulse_d = '0;
        for (int i = 0; i < N_REGS; i++) begin
            w_pulse_d[i] = w_commit_wr && (w_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_pulse_d;
        end
    end

    assign wr_pulse = r_wr_pulse;

    for (genvar g = 0; g < N_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = hw_in[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] r_val;

            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    r_val <= DATA_WIDTH'(g);
                end else if (w_commit_wr && (w_idx == IDX_W'(g))) begin
                    r_val <= DATA_WIDTH'(strobe_merge(MAX_DW'(r_val), MAX_DW'(pwdata),
                                                      MAX_SW'(pstrb)));
                end
            end

            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_val;
        end
    end

    // hw_in slices of writable registers and the upper pprot bits have no function here.
    assign w_unused = ^{hw_in, pprot};

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench for apb_regbank_slave: one instance with no wait states and a read-only
// register 0, one with three wait states; both share the APB bus apart from psel.
module tb_apb_regbank_slave;

    localparam int          DW   = 32;
    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic           pclk = 1'b0;
    logic           presetn = 1'b0;
    logic [31:0]    paddr = '0;
    logic [2:0]     pprot = 3'b001;
    logic           psel0 = 1'b0;
    logic           psel3 = 1'b0;
    logic           penable = 1'b0;
    logic           pwrite = 1'b0;
    logic [31:0]    pwdata = '0;
    logic [3:0]     pstrb = '0;
    logic           pready0, pready3, pslverr0, pslverr3;
    logic [31:0]    prdata0, prdata3;
    logic [NR*DW-1:0] reg_out0, reg_out3, hw_in;
    logic [NR-1:0]  wr_pulse0, wr_pulse3;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          waits;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   acc = 0;

    always #5 pclk = ~pclk;

    apb_regbank_slave #(
        .BASE_ADDR   (BASE),
        .DATA_WIDTH  (DW),
        .N_REGS      (NR),
        .WAIT_STATES (0),
        .RO_MASK     (8'h01)
    ) u_dut0 (
        .pclk     (pclk),
        .presetn  (presetn),
        .paddr    (paddr),
        .pprot    (pprot),
        .psel     (psel0),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pready   (pready0),
        .prdata   (prdata0),
        .pslverr  (pslverr0),
        .reg_out  (reg_out0),
        .hw_in    (hw_in),
        .wr_pulse (wr_pulse0)
    );

    apb_regbank_slave #(
        .BASE_ADDR   (BASE),
        .DATA_WIDTH  (DW),
        .N_REGS      (NR),
        .WAIT_STATES (3),
        .RO_MASK     (8'h00)
    ) u_dut3 (
        .pclk     (pclk),
        .presetn  (presetn),
        .paddr    (paddr),
        .pprot    (pprot),
        .psel     (psel3),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pready   (pready3),
        .prdata   (prdata3),
        .pslverr  (pslverr3),
        .reg_out  (reg_out3),
        .hw_in    (hw_in),
        .wr_pulse (wr_pulse3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed transfer, also checks wait-state count.
    always @(negedge pclk) begin
        exp_t        e;
        int          which;
        logic [31:0] rd;
        logic        er;
        if (!presetn) begin
            acc = 0;
        end else if (pready0 || pready3) begin
            which = pready3 ? 3 : 0;
            rd    = pready3 ? prdata3 : prdata0;
            er    = pready3 ? pslverr3 : pslverr0;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pready: got dut%0d ready expected none", which);
            end else begin
                e = q.pop_front();
                check({e.name, " dut"}, 64'(which), 64'(e.dut));
                check({e.name, " prdata"}, 64'(rd), 64'(e.rdata));
                check({e.name, " pslverr"}, 64'(er), 64'(e.err));
                check({e.name, " waits"}, 64'(acc), 64'(e.waits));
            end
            acc = 0;
        end else if ((psel0 || psel3) && penable) begin
            acc++;
        end
    end

    task automatic xfer(input int dut, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input logic [7:0] exp_pulse, input string name);
        exp_t e;
        int   n;
        logic rdy;
        e.dut   = dut;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.waits = (dut == 0) ? 0 : 3;
        e.name  = name;
        q.push_back(e);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        penable = 1'b0;
        psel0   = (dut == 0);
        psel3   = (dut == 3);
        @(posedge pclk);
        #1 penable = 1'b1;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(negedge pclk);
            rdy = (dut == 0) ? pready0 : pready3;
            n++;
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no pready expected pready within 40 cycles", name);
        end
        @(posedge pclk);
        #1;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        check({name, " wr_pulse"}, 64'((dut == 0) ? wr_pulse0 : wr_pulse3), 64'(exp_pulse));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            hw_in[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
        end
        hw_in[31:0] = 32'h0000_1234;

        repeat (3) @(posedge pclk);
        #1;
        check("rst pready0", 64'(pready0), 0);
        check("rst pready3", 64'(pready3), 0);
        check("rst prdata0", 64'(prdata0), 0);
        check("rst pslverr0", 64'(pslverr0), 0);
        check("rst wr_pulse0", 64'(wr_pulse0), 0);
        check("rst wr_pulse3", 64'(wr_pulse3), 0);
        check("rst dut3 reg2", 64'(reg_out3[2*DW +: DW]), 64'h2);
        check("rst dut3 reg7", 64'(reg_out3[7*DW +: DW]), 64'h7);
        check("rst dut0 reg0 ro", 64'(reg_out0[0 +: DW]), 64'h1234);
        check("rst dut0 reg1", 64'(reg_out0[1*DW +: DW]), 64'h1);

        presetn = 1'b1;
        @(posedge pclk);
        #1;

        // Back-to-back transfers: each call issues its setup right after the previous completes.
        xfer(0, 1'b1, BASE + 4, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 8'h02, "w0_wr_r1");
        xfer(0, 1'b0, BASE + 4, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 8'h00, "w0_rd_r1");
        xfer(3, 1'b0, BASE + 8, 32'h0, 4'hF, 32'h2, 1'b0, 8'h00, "w3_rd_r2");
        xfer(3, 1'b1, BASE + 8, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 8'h04, "w3_wr_strb");
        xfer(3, 1'b0, BASE + 8, 32'h0, 4'hF, 32'h00BB_00DD, 1'b0, 8'h00, "w3_rd_strb");
        xfer(3, 1'b1, BASE + 12, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 8'h08, "w3_wr_nostrb");
        xfer(3, 1'b0, BASE + 12, 32'h0, 4'hF, 32'h3, 1'b0, 8'h00, "w3_rd_nostrb");
        xfer(0, 1'b0, BASE, 32'h0, 4'hF, 32'h1234, 1'b0, 8'h00, "w0_rd_ro");
        xfer(0, 1'b1, BASE, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 8'h00, "w0_wr_ro");
        xfer(0, 1'b0, BASE, 32'h0, 4'hF, 32'h1234, 1'b0, 8'h00, "w0_rd_ro_again");
        @(posedge pclk);
        #1;
        xfer(0, 1'b0, BASE + 32, 32'h0, 4'hF, 32'h0, 1'b1, 8'h00, "w0_rd_miss_hi");
        xfer(3, 1'b1, BASE + 32, 32'h7777_7777, 4'hF, 32'h0, 1'b1, 8'h00, "w3_wr_miss_hi");
        xfer(0, 1'b0, BASE + 2, 32'h0, 4'hF, 32'h0, 1'b1, 8'h00, "w0_rd_misalign");
        xfer(0, 1'b1, BASE + 6, 32'h1111_1111, 4'hF, 32'h0, 1'b1, 8'h00, "w0_wr_misalign");
        xfer(0, 1'b0, BASE - 4, 32'h0, 4'hF, 32'h0, 1'b1, 8'h00, "w0_rd_miss_lo");
        xfer(3, 1'b0, BASE + 28, 32'h0, 4'hF, 32'h7, 1'b0, 8'h00, "w3_rd_last");
        check("dut0 reg1 after errors", 64'(reg_out0[1*DW +: DW]), 64'hDEAD_BEEF);
        check("dut3 reg0 after miss", 64'(reg_out3[0 +: DW]), 64'h0);
        check("dut0 reg0 still hw", 64'(reg_out0[0 +: DW]), 64'h1234);

        // Reset asserted on the cycle the 3-wait write to reg 2 would complete.
        paddr   = BASE + 8;
        pwrite  = 1'b1;
        pwdata  = 32'h1234_5678;
        pstrb   = 4'hF;
        psel3   = 1'b1;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        check("pre-reset pready3", 64'(pready3), 64'h1);
        presetn = 1'b0;
        #1;
        check("mid-reset pready3", 64'(pready3), 0);
        check("mid-reset pslverr3", 64'(pslverr3), 0);
        check("mid-reset prdata3", 64'(prdata3), 0);
        psel3   = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1;
        check("mid-reset wr_pulse3", 64'(wr_pulse3), 0);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        check("post-reset dut3 reg2", 64'(reg_out3[2*DW +: DW]), 64'h2);
        check("post-reset dut0 reg1", 64'(reg_out0[1*DW +: DW]), 64'h1);
        xfer(3, 1'b0, BASE + 8, 32'h0, 4'hF, 32'h2, 1'b0, 8'h00, "w3_rd_after_reset");

        repeat (2) @(posedge pclk);
        #1;
        check("scoreboard drained", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
Parametrised APB4 slave register bank, the successor to the single-cycle template slave.
- Adds byte-strobe writes, per-register read-only lanes fed by hardware, programmable wait states, and alignment/read-only error responses.
- Adds one-cycle write-notify pulses towards the user logic.
- Sits behind the APB interconnect as a generic control/status block.

Parameters:
BASE_ADDR, 0, byte address of register 0
DATA_WIDTH, 32, bus and register width (32 or 64)
N_REGS, 8, number of registers (>=2)
WAIT_STATES, 0, extra access-phase cycles before pready (0..15)
RO_MASK, 0, N_REGS-bit mask; bit i=1 makes register i read-only, value taken from hw_in

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
paddr  in  32  APB address
pprot  in  3  APB protection
psel  in  1  slave select
penable  in  1  access phase
pwrite  in  1  1=write
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  byte-lane strobes
pready  out  1  transfer complete
prdata  out  DATA_WIDTH  read data
pslverr  out  1  error response, valid with pready
reg_out  out  N_REGS*DATA_WIDTH  flattened register contents (reg i at [i*DW +: DW])
hw_in  in  N_REGS*DATA_WIDTH  hardware values for RO registers (same packing)
wr_pulse  out  N_REGS  one-cycle pulse per register on committed write

Behaviour:
- One clock (pclk). Reset is asynchronous and active-low (presetn).
- Reset values:
  - Writable register i resets to i.
  - pready=0, prdata=0, pslverr=0, wr_pulse=0.
  - FSM in IDLE, wait counter=0.
- Decode:
  - STRIDE=DATA_WIDTH/8.
  - offset=paddr-BASE_ADDR; idx=offset/STRIDE.
  - Hit when BASE_ADDR <= paddr < BASE_ADDR+N_REGS*STRIDE.
  - Misaligned when offset mod STRIDE != 0.
- FSM:
  - IDLE: on psel & !penable (setup), load cnt=WAIT_STATES, go ACCESS.
  - ACCESS with psel & penable:
    - cnt!=0: pready=0, cnt decrements.
    - cnt==0: pready=1 (combinational from state/cnt), commit, go IDLE.
  - ACCESS with psel=0 (abort): go IDLE, no commit, no pulse.
- Latency: pready rises WAIT_STATES cycles after the first access cycle. WAIT_STATES=0 gives a classic 2-cycle transfer.
- Back-to-back: a setup phase in the cycle after completion is accepted from IDLE with no idle gap.
- Error: pslverr=pready & (miss | misaligned | (pwrite & RO_MASK[idx])). An errored transfer commits nothing and returns prdata=0.
- Write commit, on the pready cycle without error:
  - Byte b of reg idx <= pwdata byte b for each pstrb[b]=1.
  - wr_pulse[idx]=1 for the next cycle only. This applies even when pstrb=0.
- Read: prdata=(pready & !pwrite & !pslverr) ? (RO_MASK[idx] ? hw_in slice : reg) : 0. Value is sampled on the pready cycle.
- reg_out for RO registers mirrors hw_in.
- Reset mid-transfer: immediate return to IDLE with outputs at reset values; the pending write is lost.

Optional Feature:
APB_PRIV_CHECK_EN
- Defined: any access with pprot[0]=0 (unprivileged) completes with pslverr=1 and no side effects. Wait states are still honoured.
- Undefined: pprot is ignored.

Decomposition:
- Package apb_regbank_pkg holds:
  - state enum {IDLE, ACCESS}
  - MAX_WAIT constant (15)
  - function strobe_merge(old, wdata, strb)
- Sub-module apb_wait_counter: load/decrement, done flag. Instantiated once.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to BASE+4, strb=4'hF -> pready in first access cycle, pslverr=0, wr_pulse[1] one cycle; read BASE+4 returns 0xDEADBEEF.
- WAIT_STATES=3: read BASE+8 -> pready low for 3 access cycles, high on 4th, prdata=0x2.
- Reg 2 = 0x00000002; write 0xAABBCCDD with strb=4'b0101 -> reg 2 = 0x00BB00DD.
- RO_MASK=8'h01, hw_in reg0=0x1234: read returns 0x1234; write -> pslverr=1, no pulse, value unchanged.
- Address BASE+N_REGS*4 and BASE+2 -> pslverr=1, prdata=0, no register changes.
- presetn low during a WAIT_STATES=3 write -> pready=0 immediately; target register holds its reset value after release.
